// File: rtl/par_pkg.sv
// par_pkg -- shared definitions for the parity serial transmitter.
//   state_e : FSM state encoding (2 bits; 2'b11 is unused and recovers to IDLE)
//   EVEN/ODD: parity-mode constants for the par_tx ODD parameter
package par_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    PAR   = 2'b10
  } state_e;

  localparam int EVEN = 0;
  localparam int ODD  = 1;

endpackage

// File: rtl/par_tx.sv
// par_tx -- parallel-to-serial transmitter with a trailing parity bit.
// A word accepted on a load/ready edge is sent LSB first on sout over WIDTH
// cycles, followed by one parity bit, so a frame is WIDTH+1 cycles long.
//
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset
//   din   in   [WIDTH-1:0] word to transmit, sampled only on a transfer edge
//   load  in   word-valid request
//   ready out  block can accept a word this cycle (state-only decode)
//   sout  out  serial data, registered
//   frame out  high while sout carries a data or parity bit, registered
//   last  out  high while sout carries the parity bit, registered
//
// Handshake: a transfer happens at a rising edge where load=1 and ready=1.
// ready depends on state alone (high in IDLE and PAR, low in SHIFT), so a
// source may hold load high; a load seen while ready=0 is simply dropped.
module par_tx #(
  parameter int WIDTH = 8,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             frame,
  output logic             last
);

  import par_pkg::state_e;
  import par_pkg::IDLE;
  import par_pkg::SHIFT;
  import par_pkg::PAR;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             par_q;
  logic             sout_q;
  logic             frame_q;
  logic             last_q;

  // Parity of the incoming word, only used on a transfer edge.
  logic par_d;
  assign par_d = (^din) ^ 1'(ODD);

  assign ready = (state_q == IDLE) || (state_q == PAR);
  assign sout  = sout_q;
  assign frame = frame_q;
  assign last  = last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      sout_q  <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        // PAR behaves like IDLE for acceptance, which is what lets frames
        // run back to back with no gap.
        IDLE, PAR: begin
          if (load) begin
            state_q <= SHIFT;
            // Bit 0 goes straight to the output register; the rest waits
            // in the shift register already aligned for the next cycle.
            shreg_q <= din >> 1;
            cnt_q   <= '0;
            par_q   <= par_d;
            sout_q  <= din[0];
            frame_q <= 1'b1;
            last_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            sout_q  <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        SHIFT: begin
          // cnt_q is the index of the bit currently on sout.
          if (cnt_q == CNT_LAST) begin
            state_q <= PAR;
            sout_q  <= par_q;
            frame_q <= 1'b1;
            last_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            sout_q  <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            frame_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          sout_q  <= 1'b0;
          frame_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_tx.sv
// tb_par_tx -- self-checking bench for par_tx (WIDTH=8), one even-parity and
// one odd-parity instance sharing clock and reset.
module tb_par_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] load_v;
  logic [7:0] din_v [2];
  logic [1:0] ready_v, sout_v, frame_v, last_v;

  par_tx #(.WIDTH(8), .ODD(par_pkg::EVEN)) u_even (
    .clk(clk), .rst_n(rst_n), .din(din_v[0]), .load(load_v[0]),
    .ready(ready_v[0]), .sout(sout_v[0]), .frame(frame_v[0]), .last(last_v[0])
  );

  par_tx #(.WIDTH(8), .ODD(par_pkg::ODD)) u_odd (
    .clk(clk), .rst_n(rst_n), .din(din_v[1]), .load(load_v[1]),
    .ready(ready_v[1]), .sout(sout_v[1]), .frame(frame_v[1]), .last(last_v[1])
  );

  // ---------------- scoreboard state ----------------
  // Each entry is {last, sout} for one frame cycle.
  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_cur[2]    = '{0, 0};
  int   last_run[2]   = '{0, 0};
  logic acc[2]        = '{1'b0, 1'b0};
  logic prev_frame[2] = '{1'b0, 1'b0};
  logic prev_last[2]  = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon(input int k);
    logic [1:0] got;
    logic [1:0] exp;
    logic       empty;
    got = {last_v[k], sout_v[k]};
    if (frame_v[k]) begin
      // Running parity: restarts on the first bit of every frame.
      if (!prev_frame[k] || prev_last[k]) acc[k] = 1'b0;
      acc[k] = acc[k] ^ sout_v[k];
      if (last_v[k]) check($sformatf("parity_model_dut%0d", k), 32'(acc[k]), 32'(k));
      empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_dut%0d: got last/sout %b required no frame bit at %0t",
                 k, got, $time);
      end else begin
        if (k == 0) exp = exp_q0.pop_front();
        else        exp = exp_q1.pop_front();
        check($sformatf("sb_bit_dut%0d", k), 32'(got), 32'(exp));
      end
      run_cur[k]++;
    end else begin
      check($sformatf("idle_outputs_dut%0d", k), 32'(got), 32'(0));
      if (run_cur[k] > 0) begin
        last_run[k] = run_cur[k];
        run_cur[k]  = 0;
      end
    end
    prev_frame[k] = frame_v[k];
    prev_last[k]  = last_v[k];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int k, input logic [7:0] w, input logic p);
    for (int i = 0; i < 8; i++) begin
      if (k == 0) exp_q0.push_back({1'b0, w[i]});
      else        exp_q1.push_back({1'b0, w[i]});
    end
    if (k == 0) exp_q0.push_back({1'b1, p});
    else        exp_q1.push_back({1'b1, p});
  endtask

  task automatic wait_ready(input int k);
    int t = 0;
    while (!ready_v[k] && t < 40) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("wait_ready_dut%0d", k), 32'(ready_v[k]), 32'(1));
  endtask

  // Called at a negedge; returns one negedge after the transfer edge.
  task automatic send(input int k, input logic [7:0] w, input logic p);
    wait_ready(k);
    din_v[k]  = w;
    load_v[k] = 1'b1;
    push_frame(k, w, p);
    @(negedge clk);
    load_v[k] = 1'b0;
  endtask

  task automatic finish(input int k, input int exp_len);
    int t = 0;
    while (frame_v[k] && t < 60) begin
      @(negedge clk);
      t++;
    end
    #1;
    check($sformatf("frame_end_dut%0d", k), 32'(frame_v[k]), 32'(0));
    check($sformatf("frame_len_dut%0d", k), 32'(last_run[k]), 32'(exp_len));
    check($sformatf("ready_idle_dut%0d", k), 32'(ready_v[k]), 32'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] w;
    int         t;
    int         k;
    rst_n     = 1'b0;
    load_v    = 2'b00;
    din_v[0]  = 8'h00;
    din_v[1]  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_ready_even", 32'(ready_v[0]), 32'(1));
    check("reset_ready_odd",  32'(ready_v[1]), 32'(1));
    check("reset_outputs_even", 32'({sout_v[0], frame_v[0], last_v[0]}), 32'(0));
    check("reset_outputs_odd",  32'({sout_v[1], frame_v[1], last_v[1]}), 32'(0));

    // Even parity, 0xA5: bits 1,0,1,0,0,1,0,1 then parity 0.
    send(0, 8'hA5, 1'b0);
    finish(0, 9);

    // Odd parity: 0x01 -> parity 0, 0x00 -> parity 1.
    send(1, 8'h01, 1'b0);
    finish(1, 9);
    send(1, 8'h00, 1'b1);
    finish(1, 9);

    // Back to back with load held: 0xFF then 0x0F, 18 contiguous frame cycles.
    wait_ready(0);
    din_v[0]  = 8'hFF;
    load_v[0] = 1'b1;
    push_frame(0, 8'hFF, 1'b0);
    @(negedge clk);
    din_v[0] = 8'h0F;
    push_frame(0, 8'h0F, 1'b0);
    t = 0;
    while (!ready_v[0] && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("b2b_par_ready", 32'(last_v[0]), 32'(1));
    @(negedge clk);
    load_v[0] = 1'b0;
    finish(0, 18);

    // Load pulsed during the third SHIFT cycle is dropped.
    send(0, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("shift_ready_low", 32'(ready_v[0]), 32'(0));
    din_v[0]  = 8'h55;
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v[0] = 1'b0;
    din_v[0]  = 8'h00;
    finish(0, 9);
    repeat (4) @(negedge clk);
    check("ignored_load_queue", 32'(exp_q0.size()), 32'(0));

    // Reset during the fourth SHIFT cycle; load on the reset edge is ignored.
    send(0, 8'hC3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    din_v[0]  = 8'hFF;
    load_v[0] = 1'b1;
    @(negedge clk);
    rst_n     = 1'b1;
    load_v[0] = 1'b0;
    check("abort_outputs", 32'({sout_v[0], frame_v[0], last_v[0]}), 32'(0));
    check("abort_ready", 32'(ready_v[0]), 32'(1));
    #1;
    check("abort_len", 32'(last_run[0]), 32'(4));
    exp_q0.delete();
    @(negedge clk);
    check("abort_stays_idle", 32'(frame_v[0]), 32'(0));
    send(0, 8'h81, 1'b0);
    finish(0, 9);

    // 1000 random words: first half even instance, second half odd instance.
    for (int i = 0; i < 1000; i++) begin
      k = (i < 500) ? 0 : 1;
      w = 8'($urandom_range(0, 255));
      wait_ready(k);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send(k, w, (^w) ^ 1'(k));
    end
    finish(1, 9);
    repeat (20) @(negedge clk);
    check("final_queue_even", 32'(exp_q0.size()), 32'(0));
    check("final_queue_odd",  32'(exp_q1.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/par_tx.md
PAR_TX -- requirements
Module: par_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter ODD, default 0, meaning parity mode: 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port din, input, WIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port load, input, 1 bit: word-valid request.
REQ-007 The block SHALL have port ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: serial data line, LSB first, followed by one parity bit.
REQ-009 The block SHALL have port frame, output, 1 bit: high while sout carries a frame bit.
REQ-010 The block SHALL have port last, output, 1 bit: high while sout carries the parity bit.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, SHIFT and PAR.
REQ-012 ready SHALL be combinational from state only: 1 in IDLE and PAR, 0 in SHIFT.
REQ-013 A transfer SHALL occur at a rising edge where load=1 and ready=1.
REQ-014 A load sampled while ready=0 SHALL be ignored, with no effect on state, shift register or outputs.
REQ-015 On transfer, the block SHALL capture din into a shift register and the parity bit p = (XOR of all din bits) XOR ODD into a register, then enter SHIFT.
REQ-016 The cycle after a transfer, sout SHALL equal din[0] with frame=1 and last=0 (latency 1 clock).
REQ-017 In SHIFT, sout SHALL present din[0] through din[WIDTH-1] on WIDTH consecutive cycles, tracked by a bit counter of clog2(WIDTH) bits.
REQ-018 When the counter reaches WIDTH-1, the next state SHALL be PAR.
REQ-019 In PAR, sout SHALL equal p, with frame=1 and last=1, for exactly one cycle.
REQ-020 A frame SHALL therefore be WIDTH+1 cycles long, and the XOR of all its sout bits SHALL equal ODD.
REQ-021 From PAR with load=1, the next state SHALL be SHIFT carrying the new word's bit 0, giving back-to-back frames with no idle gap.
REQ-022 From PAR with load=0, the next state SHALL be IDLE.
REQ-023 In IDLE, the outputs SHALL be sout=0, frame=0, last=0.
REQ-024 sout, frame and last SHALL be driven directly from registers, with no combinational path from din or load.
REQ-025 The state encoding SHALL be 2 bits; the unused encoding SHALL return to IDLE on the next edge with sout, frame and last forced to 0.
REQ-026 din SHALL be sampled only on the transfer edge; changes to din at any other time SHALL NOT affect the frame in progress.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, the shift register, counter and p to 0, and sout=0, frame=0, last=0.
REQ-028 ready SHALL read 1 during the first cycle after reset is released.
REQ-029 A reset asserted mid-frame SHALL abort the frame at that edge with no parity bit emitted; load SHALL be ignored on any edge where rst_n=0.

Structure
REQ-030 A shared package par_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the parity-mode constants EVEN=0 and ODD=1.
REQ-031 The block SHALL be a single module with no sub-modules; the parity reduction SHALL be inline.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, ODD=0, load din=8'hA5 from IDLE -> sout 1,0,1,0,0,1,0,1 then parity bit 0; frame high 9 cycles; last high on cycle 9 only.
REQ-033 The bench SHALL cover: WIDTH=8, ODD=1, din=8'h01 -> data bits 1,0,0,0,0,0,0,0 then parity bit 0; din=8'h00 -> parity bit 1.
REQ-034 The bench SHALL cover: back-to-back, load held high with 8'hFF then 8'h0F -> 18 contiguous frame cycles with no frame=0 gap; both parity bits 0 (even mode).
REQ-035 The bench SHALL cover: load=1 pulsed during SHIFT cycle 3 with din=8'h55 -> ignored, the current frame completes unchanged, and the block returns to IDLE.
REQ-036 The bench SHALL cover: rst_n=0 at SHIFT cycle 4 -> next cycle sout=0, frame=0, last=0, ready=1; a subsequent load starts a clean frame.
REQ-037 The bench SHALL carry a checker that feeds sout gated by frame into a running-parity model, reset at each frame start, and asserts the result equals ODD whenever last=1, over 1000 random words.
